// File: rtl/huff_pkg.sv
// Shared constants, node/weight types and FSM state encoding for the
// Huffman merge sequencer.
package huff_pkg;

    localparam int unsigned N_LEAF  = 8;
    localparam int unsigned WGT_W   = 5;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned N_ROUND = 7;

    typedef logic [ID_W-1:0]  node_id_t;
    typedef logic [WGT_W-1:0] weight_t;

    localparam node_id_t PAD_ID  = 4'd15;
    localparam weight_t  PAD_WGT = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        MERGE
    } state_t;

    // Add two weights through a one-bit-wider intermediate, clamping at all-ones.
    function automatic weight_t sat_add(input weight_t a, input weight_t b);
        logic [WGT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WGT_W] ? '1 : s[WGT_W-1:0];
    endfunction

endpackage

// File: rtl/SORT_IP.sv
// Combinational rank sort of IP_WIDTH (id, weight) lanes, lightest id first.
// Equal weights keep lane order: the higher lane ranks heavier.
module SORT_IP #(
    parameter int unsigned IP_WIDTH = 8,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned WGT_W    = 5
) (
    input  logic [IP_WIDTH*ID_W-1:0]  in_ids,
    input  logic [IP_WIDTH*WGT_W-1:0] in_wgts,
    output logic [IP_WIDTH*ID_W-1:0]  out_ids
);

    localparam int unsigned RANK_W = $clog2(IP_WIDTH);

    logic [RANK_W-1:0] rank;
    logic [WGT_W-1:0]  wi;
    logic [WGT_W-1:0]  wj;

    // Each lane's rank is the number of lanes that beat it; ranks form a permutation.
    always_comb begin
        out_ids = '0;
        rank    = '0;
        wi      = '0;
        wj      = '0;
        for (int unsigned i = 0; i < IP_WIDTH; i++) begin
            rank = '0;
            wi   = in_wgts[i*WGT_W +: WGT_W];
            for (int unsigned j = 0; j < IP_WIDTH; j++) begin
                wj = in_wgts[j*WGT_W +: WGT_W];
                if ((wj < wi) || ((wj == wi) && (j < i)))
                    rank = rank + 1'b1;
            end
            out_ids[rank*ID_W +: ID_W] = in_ids[i*ID_W +: ID_W];
        end
    end

endmodule

// File: rtl/huffman_merge_ctrl.sv
// Builds an 8-leaf Huffman merge schedule: serial leaf load, then seven
// SORT/MERGE rounds, each emitting one (left, right, sum) record.
module huffman_merge_ctrl #(
    parameter int unsigned N_LEAF = 8,
    parameter int unsigned WGT_W  = 5,
    parameter int unsigned ID_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WGT_W-1:0] in_weight,
    output logic             busy,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_left,
    output logic [ID_W-1:0]  out_right,
    output logic [WGT_W-1:0] out_sum,
    output logic             out_done
);

    import huff_pkg::*;

    localparam int unsigned CNT_W  = $clog2(N_LEAF + 1);
    localparam int unsigned SLOT_W = $clog2(N_LEAF);
    localparam int unsigned R_W    = $clog2(N_ROUND);
    localparam int unsigned N_NODE = 2 * N_LEAF - 1;
    localparam logic [R_W-1:0] LAST_ROUND = R_W'(N_ROUND - 1);

    state_t state, state_nx;

    logic [WGT_W-1:0] tbl  [N_NODE];
    logic [ID_W-1:0]  slot [N_LEAF];
    logic [ID_W-1:0]  srt  [N_LEAF];
    logic [CNT_W-1:0] n;
    logic [R_W-1:0]   r;

    logic                      accept;
    logic                      merge;
    logic [N_LEAF*ID_W-1:0]    lane_ids;
    logic [N_LEAF*WGT_W-1:0]   lane_wgts;
    logic [N_LEAF*ID_W-1:0]    sorted_ids;
    logic [ID_W-1:0]           srt_in [N_LEAF];
    logic [ID_W-1:0]           left_id;
    logic [ID_W-1:0]           right_id;
    logic [ID_W-1:0]           new_id;
    logic [WGT_W-1:0]          sum;
    logic [ID_W-1:0]           slot_nx [N_LEAF];

    always_comb begin
        lane_ids  = '0;
        lane_wgts = '0;
        for (int unsigned k = 0; k < N_LEAF; k++) begin
            lane_ids[k*ID_W +: ID_W]    = slot[k];
            lane_wgts[k*WGT_W +: WGT_W] = (slot[k] == PAD_ID) ? PAD_WGT : tbl[slot[k]];
        end
    end

    SORT_IP #(
        .IP_WIDTH (N_LEAF),
        .ID_W     (ID_W),
        .WGT_W    (WGT_W)
    ) u_sort (
        .in_ids  (lane_ids),
        .in_wgts (lane_wgts),
        .out_ids (sorted_ids)
    );

    always_comb begin
        for (int unsigned k = 0; k < N_LEAF; k++)
            srt_in[k] = sorted_ids[k*ID_W +: ID_W];
    end

    // Survivors shift down two slots; the new internal node lands right after them.
    always_comb begin
        left_id  = srt[0];
        right_id = srt[1];
        new_id   = ID_W'(N_LEAF) + ID_W'(r);
        sum      = sat_add(tbl[left_id], tbl[right_id]);
        for (int unsigned k = 0; k < N_LEAF; k++)
            slot_nx[k] = PAD_ID;
        for (int unsigned k = 0; k < N_LEAF - 2; k++) begin
            if (CNT_W'(k + 2) < n)
                slot_nx[k] = srt[k+2];
        end
        slot_nx[SLOT_W'(n - CNT_W'(2))] = new_id;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        merge    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (n == CNT_W'(N_LEAF - 1))
                        state_nx = SORT;
                end
            end
            SORT:  state_nx = MERGE;
            MERGE: begin
                merge    = 1'b1;
                state_nx = (r == LAST_ROUND) ? IDLE : SORT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n         <= '0;
            r         <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_done  <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            out_sum   <= '0;
            for (int unsigned k = 0; k < N_LEAF; k++) begin
                slot[k] <= PAD_ID;
                srt[k]  <= PAD_ID;
            end
            for (int unsigned k = 0; k < N_NODE; k++)
                tbl[k] <= '0;
        end else begin
            // Busy stays up through the cycle after the last merge.
            busy      <= (state != IDLE) || in_valid;
            out_valid <= merge;
            out_done  <= merge && (r == LAST_ROUND);
            if (accept) begin
                tbl[n]                <= in_weight;
                slot[n[SLOT_W-1:0]]   <= ID_W'(n);
                n                     <= n + 1'b1;
            end
            if (state == SORT)
                srt <= srt_in;
            if (merge) begin
                out_left    <= left_id;
                out_right   <= right_id;
                out_sum     <= sum;
                tbl[new_id] <= sum;
                slot        <= slot_nx;
                if (r == LAST_ROUND) begin
                    n <= '0;
                    r <= '0;
                end else begin
                    n <= n - 1'b1;
                    r <= r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// Scoreboard bench for huffman_merge_ctrl: driver pushes hand-computed merge
// records with their expected output cycle; a negedge monitor pops and compares.
module tb_huffman_merge_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_weight = '0;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_left;
    logic [3:0] out_right;
    logic [4:0] out_sum;
    logic       out_done;

    always #5 clk = ~clk;

    huffman_merge_ctrl #(
        .N_LEAF (8),
        .WGT_W  (5),
        .ID_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_weight (in_weight),
        .busy      (busy),
        .out_valid (out_valid),
        .out_left  (out_left),
        .out_right (out_right),
        .out_sum   (out_sum),
        .out_done  (out_done)
    );

    typedef struct {
        int l;
        int r;
        int s;
        int d;
        int cyc;
    } rec_t;

    rec_t sb[$];
    rec_t mon_rec;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    int wts[3][8] = '{'{1, 2, 3, 4, 5, 6, 7, 3},
                      '{2, 2, 2, 2, 2, 2, 2, 2},
                      '{20, 20, 0, 0, 0, 0, 0, 0}};
    int sched_l[3][7] = '{'{0, 2, 8, 4, 9, 10, 12},
                          '{0, 2, 4, 6, 8, 10, 12},
                          '{2, 4, 6, 8, 10, 12, 1}};
    int sched_r[3][7] = '{'{1, 7, 3, 5, 6, 11, 13},
                          '{1, 3, 5, 7, 9, 11, 13},
                          '{3, 5, 7, 9, 11, 0, 13}};
    int sched_s[3][7] = '{'{3, 6, 7, 11, 13, 18, 31},
                          '{4, 4, 4, 4, 8, 8, 16},
                          '{0, 0, 0, 0, 0, 20, 31}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_sched(input int sel, input int t, input int nrec);
        rec_t x;
        for (int k = 0; k < nrec; k++) begin
            x.l   = sched_l[sel][k];
            x.r   = sched_r[sel][k];
            x.s   = sched_s[sel][k];
            x.d   = (k == 6) ? 1 : 0;
            x.cyc = t + 2 * (k + 1);
            sb.push_back(x);
        end
    endtask

    // Drives 8 beats with 'gap' idle cycles between them; t = edge of last beat.
    task automatic load(input int sel, input int gap, output int t);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_weight = 5'(wts[sel][i]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i == 0)
                check("busy_rise", busy, 1);
            if (i < 7)
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
        end
        t = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy)
            check("idle_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out_valid: got left=%0d right=%0d sum=%0d, expected no record (cycle %0d)",
                         out_left, out_right, out_sum, cyc);
            end else begin
                mon_rec = sb.pop_front();
                check("out_left", out_left, mon_rec.l);
                check("out_right", out_right, mon_rec.r);
                check("out_sum", out_sum, mon_rec.s);
                check("out_done", out_done, mon_rec.d);
                check("out_cycle", cyc, mon_rec.cyc);
            end
        end else if (out_done) begin
            check("done_without_valid", out_done, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_done", out_done, 0);
        check("reset_out_left", out_left, 0);
        check("reset_out_right", out_right, 0);
        check("reset_out_sum", out_sum, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mixed weights; in_valid held high through all 14 sequencing edges.
        load(0, 0, t);
        push_sched(0, t, 7);
        for (int i = 1; i <= 14; i++) begin
            in_valid  = 1'b1;
            in_weight = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("busy_last_merge", busy, 1);
        @(posedge clk);
        #1;
        check("busy_fall", busy, 0);

        // Equal weights, then a saturating load whose first beat lands at t+15.
        load(1, 0, t);
        push_sched(1, t, 7);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        load(2, 0, t);
        push_sched(2, t, 7);
        wait_idle();

        // Reset during the SORT cycle of round 3, then a fresh full load.
        load(1, 0, t);
        push_sched(1, t, 2);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_done", out_done, 0);
        check("midrst_out_left", out_left, 0);
        check("midrst_out_right", out_right, 0);
        check("midrst_out_sum", out_sum, 0);
        load(0, 0, t);
        push_sched(0, t, 7);
        wait_idle();

        // Gapped load must yield the same schedule as back-to-back.
        load(0, 2, t);
        push_sched(0, t, 7);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
